// File: rtl/partition_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// partition_alloc_ctrl_if
// Request/response bundle between the PNEW issue logic (master) and the
// partition allocation sequencer (slave).
//   req_valid / req_ready / req_mask      : allocation request handshake
//   rsp_valid / rsp_id / rsp_new /
//   rsp_full / rsp_err                    : one-cycle response, no back-pressure
// ---------------------------------------------------------------------------
interface partition_alloc_ctrl_if #(
  parameter int REGION_W = 64,
  parameter int ID_W     = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [REGION_W-1:0] req_mask;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_new;
  logic                rsp_full;
  logic                rsp_err;

  modport master (
    output req_valid, req_mask,
    input  req_ready, rsp_valid, rsp_id, rsp_new, rsp_full, rsp_err
  );

  modport slave (
    input  req_valid, req_mask,
    output req_ready, rsp_valid, rsp_id, rsp_new, rsp_full, rsp_err
  );
endinterface

// File: rtl/partition_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// partition_alloc_ctrl
// Sequences PNEW allocation requests against the partition/module table.
// Each request scans the table in index order for an identical region mask;
// a hit returns the stored ID, a miss appends {next_id, mask} and charges
// popcount(mask) to mu_discovery. The table starts with entry 0 = {id 0,
// mask 1} and entries are never freed.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   bus (slave)    request handshake and one-cycle response pulse
//   num_modules    number of valid table entries
//   next_id        ID the next created entry receives (wraps)
//   mu_discovery   accumulated discovery cost
//   busy           high whenever a request cannot be accepted
//
// Build option
//   PALLOC_MU_SAT_EN  defined: mu_discovery saturates at all-ones
//                     undefined: mu_discovery wraps modulo 2^MU_W
// ---------------------------------------------------------------------------
module partition_alloc_ctrl #(
  parameter int NUM_MODULES = 64,
  parameter int REGION_W    = 64,
  parameter int ID_W        = 32,
  parameter int MU_W        = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  partition_alloc_ctrl_if.slave         bus,
  output logic [$clog2(NUM_MODULES):0]  num_modules,
  output logic [ID_W-1:0]               next_id,
  output logic [MU_W-1:0]               mu_discovery,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_MODULES);
  localparam int CNT_W = IDX_W + 1;
  localparam int PC_W  = $clog2(REGION_W + 1);
  localparam int SUM_W = ((MU_W > PC_W) ? MU_W : PC_W) + 1;

  localparam logic [MU_W-1:0] MU_MAX = {MU_W{1'b1}};

  // A match goes straight from SCAN to RESP so the response lands one cycle
  // after the comparing cycle; there is no separate MATCH state register value.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_COMMIT = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;

  function automatic logic [PC_W-1:0] popcount(input logic [REGION_W-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < REGION_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  logic [2:0]          state_r, state_nx;
  logic [IDX_W-1:0]    idx_r, idx_nx;
  logic [REGION_W-1:0] mask_r;
  logic [REGION_W-1:0] tbl_mask_r [NUM_MODULES];
  logic [ID_W-1:0]     tbl_id_r   [NUM_MODULES];
  logic [CNT_W-1:0]    num_r;
  logic [ID_W-1:0]     next_id_r;
  logic [MU_W-1:0]     mu_r, mu_nx;
  logic                ready_r, busy_r;
  logic                rsp_valid_r, rsp_new_r, rsp_full_r, rsp_err_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic                rsp_new_nx, rsp_full_nx, rsp_err_nx;
  logic [ID_W-1:0]     rsp_id_nx;
  logic                accept_s, hit_s, last_s, commit_s;
  logic [PC_W-1:0]     pop_s;

  assign accept_s = bus.req_valid & ready_r & (state_r == ST_IDLE);
  assign pop_s    = popcount(mask_r);

  // Next-state, scan control and response field selection.
  always_comb begin
    state_nx    = state_r;
    idx_nx      = idx_r;
    rsp_id_nx   = {ID_W{1'b0}};
    rsp_new_nx  = 1'b0;
    rsp_full_nx = 1'b0;
    rsp_err_nx  = 1'b0;
    commit_s    = 1'b0;
    hit_s       = (tbl_mask_r[idx_r] == mask_r);
    last_s      = ((CNT_W'(idx_r) + CNT_W'(1)) == num_r);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.req_mask == {REGION_W{1'b0}}) begin
            state_nx   = ST_RESP;
            rsp_err_nx = 1'b1;
          end else begin
            state_nx = ST_SCAN;
            idx_nx   = {IDX_W{1'b0}};
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          state_nx  = ST_RESP;
          rsp_id_nx = tbl_id_r[idx_r];
        end else if (last_s) begin
          state_nx = ST_COMMIT;
        end else begin
          idx_nx = idx_r + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        state_nx = ST_RESP;
        if (num_r < CNT_W'(NUM_MODULES)) begin
          commit_s   = 1'b1;
          rsp_new_nx = 1'b1;
          rsp_id_nx  = next_id_r;
        end else begin
          rsp_full_nx = 1'b1;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

`ifdef PALLOC_MU_SAT_EN
  logic [SUM_W-1:0] sum_s;

  // Saturating discovery-cost accumulation; the sum is formed one bit wider
  // than either operand so an overflow is visible before clamping.
  always_comb begin
    sum_s = SUM_W'(mu_r) + SUM_W'(pop_s);
    if (sum_s > SUM_W'(MU_MAX)) begin
      mu_nx = MU_MAX;
    end else begin
      mu_nx = sum_s[MU_W-1:0];
    end
  end
`else
  // Wrapping discovery-cost accumulation.
  always_comb begin
    mu_nx = mu_r + MU_W'(pop_s);
  end
`endif

  // Sequencer state, handshake and registered response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      mask_r      <= {REGION_W{1'b0}};
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_new_r   <= 1'b0;
      rsp_full_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx;
      idx_r       <= idx_nx;
      rsp_valid_r <= (state_nx == ST_RESP);
      rsp_id_r    <= rsp_id_nx;
      rsp_new_r   <= rsp_new_nx;
      rsp_full_r  <= rsp_full_nx;
      rsp_err_r   <= rsp_err_nx;
      if (accept_s) begin
        mask_r  <= bus.req_mask;
        ready_r <= 1'b0;
        busy_r  <= 1'b1;
      end else if (state_r == ST_RESP) begin
        ready_r <= 1'b1;
        busy_r  <= 1'b0;
      end
    end
  end

  // Partition table storage; new entries append at index num_modules.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MODULES; i++) begin
        tbl_mask_r[i] <= (i == 0) ? {{(REGION_W-1){1'b0}}, 1'b1} : {REGION_W{1'b0}};
        tbl_id_r[i]   <= {ID_W{1'b0}};
      end
    end else if (commit_s) begin
      tbl_mask_r[num_r[IDX_W-1:0]] <= mask_r;
      tbl_id_r[num_r[IDX_W-1:0]]   <= next_id_r;
    end
  end

  // Entry count, ID allocator and discovery-cost accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_r     <= CNT_W'(1);
      next_id_r <= ID_W'(1);
      mu_r      <= MU_W'(1);
    end else if (commit_s) begin
      num_r     <= num_r + CNT_W'(1);
      next_id_r <= next_id_r + ID_W'(1);
      mu_r      <= mu_nx;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_new   = rsp_new_r;
  assign bus.rsp_full  = rsp_full_r;
  assign bus.rsp_err   = rsp_err_r;
  assign num_modules   = num_r;
  assign next_id       = next_id_r;
  assign mu_discovery  = mu_r;
  assign busy          = busy_r;

endmodule
